// File: rtl/sc_random_pkg.sv
// rtl/sc_random_pkg.sv - shared types and constants for the bounded random generator
package sc_random_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } scState_t;

    // Width of the rejection-retry counter; bounds MAXTRIES to 255.
    localparam int TRIES_W = 8;

    // Maximal-length Fibonacci tap masks (bit i = reg[i] feeds the XOR).
    function automatic logic [31:0] maxLenTaps(input int width);
        case (width)
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/sc_random_lfsr_core.sv
// rtl/sc_random_lfsr_core.sv - Fibonacci LFSR register with seed load and lock-up guard
module sc_random_lfsr_core
    import sc_random_pkg::*;
#(
    parameter int                   DATAWIDTH = 8,
    parameter logic [DATAWIDTH-1:0] TAP_MASK  = 8'hB8,
    parameter logic [DATAWIDTH-1:0] SEED      = DATAWIDTH'(1)
) (
    input  logic                 clk50,
    input  logic                 resetLow,
    input  logic                 shiftEn,
    input  logic                 loadEn,
    input  logic [DATAWIDTH-1:0] loadValue,
    output logic [DATAWIDTH-1:0] lfsrState
);

    logic [DATAWIDTH-1:0] nxtRaw;
    logic [DATAWIDTH-1:0] nxtSafe;
    logic [DATAWIDTH-1:0] loadSafe;

    // An all-zero state would lock the LFSR forever, so zero is replaced by SEED.
    assign nxtRaw   = {lfsrState[DATAWIDTH-2:0], ^(lfsrState & TAP_MASK)};
    assign nxtSafe  = (nxtRaw == '0) ? SEED : nxtRaw;
    assign loadSafe = (loadValue == '0) ? SEED : loadValue;

    // Seed load has priority; otherwise advance only when the FSM asks.
    always_ff @(posedge clk50 or negedge resetLow) begin
        if (!resetLow) begin
            lfsrState <= SEED;
        end else if (loadEn) begin
            lfsrState <= loadSafe;
        end else if (shiftEn) begin
            lfsrState <= nxtSafe;
        end
    end

endmodule

// File: rtl/sc_random_lfsr.sv
// rtl/sc_random_lfsr.sv - request/valid random generator with range rejection sampling
module sc_random_lfsr
    import sc_random_pkg::*;
#(
    parameter int                   DATAWIDTH = 8,
    parameter logic [DATAWIDTH-1:0] TAP_MASK  = 8'hB8,
    parameter logic [DATAWIDTH-1:0] SEED      = DATAWIDTH'(1),
    parameter int                   STEPS     = 1,
    parameter int                   MAXTRIES  = 8
) (
    input  logic                 SC_RANDOM_CLOCK_50,
    input  logic                 SC_RANDOM_RESET_InLow,
    input  logic                 SC_RANDOM_req_In,
    input  logic [DATAWIDTH-1:0] SC_RANDOM_range_InBUS,
    input  logic                 SC_RANDOM_seedLoad_In,
    input  logic [DATAWIDTH-1:0] SC_RANDOM_seed_InBUS,
    output logic [DATAWIDTH-1:0] SC_RANDOM_data_OutBUS,
    output logic                 SC_RANDOM_valid_Out,
    output logic                 SC_RANDOM_busy_Out,
    output logic                 SC_RANDOM_fallback_Out,
    output logic [DATAWIDTH-1:0] SC_RANDOM_state_OutBUS
);

    localparam int                 CNT_W     = $clog2(DATAWIDTH);
    localparam logic [CNT_W-1:0]   STEP_LAST = CNT_W'(STEPS - 1);
    localparam logic [TRIES_W-1:0] TRY_LAST  = TRIES_W'(MAXTRIES - 1);

    scState_t             state;
    logic [CNT_W-1:0]     cnt;
    logic [TRIES_W-1:0]   tries;
    logic [DATAWIDTH-1:0] rangeLatch;
    logic [DATAWIDTH-1:0] lfsrValue;
    logic                 loadEn;
    logic                 shiftEn;

    assign loadEn  = (state == ST_IDLE) && SC_RANDOM_seedLoad_In;
    assign shiftEn = (state == ST_SHIFT);

    sc_random_lfsr_core #(
        .DATAWIDTH (DATAWIDTH),
        .TAP_MASK  (TAP_MASK),
        .SEED      (SEED)
    ) u_core (
        .clk50     (SC_RANDOM_CLOCK_50),
        .resetLow  (SC_RANDOM_RESET_InLow),
        .shiftEn   (shiftEn),
        .loadEn    (loadEn),
        .loadValue (SC_RANDOM_seed_InBUS),
        .lfsrState (lfsrValue)
    );

    assign SC_RANDOM_busy_Out     = (state != ST_IDLE);
    assign SC_RANDOM_state_OutBUS = lfsrValue;

    // Draw sequencer: shift STEPS times, then accept, retry or fall back to zero.
    always_ff @(posedge SC_RANDOM_CLOCK_50 or negedge SC_RANDOM_RESET_InLow) begin
        if (!SC_RANDOM_RESET_InLow) begin
            state                  <= ST_IDLE;
            cnt                    <= '0;
            tries                  <= '0;
            rangeLatch             <= '0;
            SC_RANDOM_data_OutBUS  <= '0;
            SC_RANDOM_valid_Out    <= 1'b0;
            SC_RANDOM_fallback_Out <= 1'b0;
        end else begin
            SC_RANDOM_valid_Out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A simultaneous seed load wins and the request is dropped.
                    if (!SC_RANDOM_seedLoad_In && SC_RANDOM_req_In) begin
                        rangeLatch             <= SC_RANDOM_range_InBUS;
                        cnt                    <= STEP_LAST;
                        tries                  <= '0;
                        SC_RANDOM_fallback_Out <= 1'b0;
                        state                  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt == '0) begin
                        state <= ST_CHECK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_CHECK: begin
                    if ((rangeLatch == '0) || (lfsrValue < rangeLatch)) begin
                        SC_RANDOM_data_OutBUS <= lfsrValue;
                        SC_RANDOM_valid_Out   <= 1'b1;
                        state                 <= ST_DONE;
                    end else if (tries == TRY_LAST) begin
                        SC_RANDOM_data_OutBUS  <= '0;
                        SC_RANDOM_fallback_Out <= 1'b1;
                        SC_RANDOM_valid_Out    <= 1'b1;
                        state                  <= ST_DONE;
                    end else begin
                        tries <= tries + 1'b1;
                        cnt   <= STEP_LAST;
                        state <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_random_lfsr.sv
// tb/tb_sc_random_lfsr.sv - directed self-checking bench for sc_random_lfsr
module tb_sc_random_lfsr;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       req = 1'b0;
    logic [7:0] range = 8'h00;
    logic       seedLoad = 1'b0;
    logic [7:0] seed = 8'h00;
    logic [1:0] sel = 2'd0;

    logic       reqA, reqB, reqC, ldA, ldB, ldC;
    logic [7:0] dataA, dataB, dataC, stA, stB, stC;
    logic       validA, validB, validC, busyA, busyB, busyC, fbA, fbB, fbC;
    logic [7:0] obsData, obsState;
    logic       obsValid, obsBusy, obsFb;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign reqA = req && (sel == 2'd0);
    assign reqB = req && (sel == 2'd1);
    assign reqC = req && (sel == 2'd2);
    assign ldA  = seedLoad && (sel == 2'd0);
    assign ldB  = seedLoad && (sel == 2'd1);
    assign ldC  = seedLoad && (sel == 2'd2);

    // Default generator
    sc_random_lfsr u_dutA (
        .SC_RANDOM_CLOCK_50(clk), .SC_RANDOM_RESET_InLow(rstN),
        .SC_RANDOM_req_In(reqA), .SC_RANDOM_range_InBUS(range),
        .SC_RANDOM_seedLoad_In(ldA), .SC_RANDOM_seed_InBUS(seed),
        .SC_RANDOM_data_OutBUS(dataA), .SC_RANDOM_valid_Out(validA),
        .SC_RANDOM_busy_Out(busyA), .SC_RANDOM_fallback_Out(fbA),
        .SC_RANDOM_state_OutBUS(stA));

    // Short retry budget
    sc_random_lfsr #(.MAXTRIES(4)) u_dutB (
        .SC_RANDOM_CLOCK_50(clk), .SC_RANDOM_RESET_InLow(rstN),
        .SC_RANDOM_req_In(reqB), .SC_RANDOM_range_InBUS(range),
        .SC_RANDOM_seedLoad_In(ldB), .SC_RANDOM_seed_InBUS(seed),
        .SC_RANDOM_data_OutBUS(dataB), .SC_RANDOM_valid_Out(validB),
        .SC_RANDOM_busy_Out(busyB), .SC_RANDOM_fallback_Out(fbB),
        .SC_RANDOM_state_OutBUS(stB));

    // Eight shifts per candidate
    sc_random_lfsr #(.STEPS(8)) u_dutC (
        .SC_RANDOM_CLOCK_50(clk), .SC_RANDOM_RESET_InLow(rstN),
        .SC_RANDOM_req_In(reqC), .SC_RANDOM_range_InBUS(range),
        .SC_RANDOM_seedLoad_In(ldC), .SC_RANDOM_seed_InBUS(seed),
        .SC_RANDOM_data_OutBUS(dataC), .SC_RANDOM_valid_Out(validC),
        .SC_RANDOM_busy_Out(busyC), .SC_RANDOM_fallback_Out(fbC),
        .SC_RANDOM_state_OutBUS(stC));

    always_comb begin
        obsData = dataA; obsState = stA; obsValid = validA; obsBusy = busyA; obsFb = fbA;
        if (sel == 2'd1) begin
            obsData = dataB; obsState = stB; obsValid = validB; obsBusy = busyB; obsFb = fbB;
        end else if (sel == 2'd2) begin
            obsData = dataC; obsState = stC; obsValid = validC; obsBusy = busyC; obsFb = fbC;
        end
    end

    function automatic logic [7:0] lfsrStep(input logic [7:0] r);
        logic [7:0] n;
        n = {r[6:0], ^(r & 8'hB8)};
        return (n == 8'h00) ? 8'h01 : n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One draw: request sampled at E0, returns edge index of valid (0 = timeout).
    task automatic draw(input logic [7:0] rng, input int limit, output int edges,
                        output logic [7:0] d, output logic f, output bit busyOk);
        range = rng;
        req = 1'b1;
        tick();
        req = 1'b0;
        edges = 0; d = 8'h00; f = 1'b0; busyOk = 1'b1;
        for (int k = 1; k <= limit; k++) begin
            if (obsBusy !== 1'b1 || obsValid !== 1'b0) busyOk = 1'b0;
            tick();
            if (obsValid === 1'b1) begin
                edges = k; d = obsData; f = obsFb;
                break;
            end
        end
        if (obsBusy !== 1'b1) busyOk = 1'b0;
        tick();
        if (obsBusy !== 1'b0 || obsValid !== 1'b0) busyOk = 1'b0;
    endtask

    int         e;
    logic [7:0] d;
    logic       f;
    bit         bOk;
    logic [7:0] expC;
    bit         seen [256];
    int         distinct;
    bit         dupOrZero;
    logic [7:0] expSeq [4];

    initial begin
        expSeq[0] = 8'h02; expSeq[1] = 8'h04; expSeq[2] = 8'h08; expSeq[3] = 8'h11;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", 32'(dataA), 32'h0);
        chk("rst_valid", 32'(validA), 32'h0);
        chk("rst_busy", 32'(busyA), 32'h0);
        chk("rst_fallback", 32'(fbA), 32'h0);
        chk("rst_state", 32'(stA), 32'h01);
        rstN = 1'b1;
        tick();

        // Four unbounded draws from SEED
        for (int i = 0; i < 4; i++) begin
            draw(8'h00, 20, e, d, f, bOk);
            chk("seq_data", 32'(d), 32'(expSeq[i]));
            chk("seq_edge", 32'(e), 32'd2);
            chk("seq_busy", 32'(bOk), 32'd1);
        end

        // Seed 0x23, range 0x40: 0x47, 0x8E rejected, 0x1C accepted at E6
        seed = 8'h23; seedLoad = 1'b1;
        tick();
        seedLoad = 1'b0;
        chk("seed_state", 32'(stA), 32'h23);
        draw(8'h40, 20, e, d, f, bOk);
        chk("rej_data", 32'(d), 32'h1C);
        chk("rej_edge", 32'(e), 32'd6);
        chk("rej_fallback", 32'(f), 32'h0);
        chk("rej_busy", 32'(bOk), 32'd1);

        // Zero seed is replaced by SEED
        seed = 8'h00; seedLoad = 1'b1;
        tick();
        seedLoad = 1'b0;
        chk("seed0_state", 32'(stA), 32'h01);

        // Seed load and request together: load wins, no draw
        seed = 8'h55; seedLoad = 1'b1; req = 1'b1;
        tick();
        seedLoad = 1'b0; req = 1'b0;
        chk("both_state", 32'(stA), 32'h55);
        chk("both_busy0", 32'(busyA), 32'h0);
        tick();
        chk("both_busy1", 32'(busyA), 32'h0);
        chk("both_valid", 32'(validA), 32'h0);

        // Reset during SHIFT aborts immediately
        range = 8'h00; req = 1'b1;
        tick();
        req = 1'b0;
        chk("pre_rst_busy", 32'(busyA), 32'h1);
        rstN = 1'b0;
        #1;
        chk("mid_rst_data", 32'(dataA), 32'h0);
        chk("mid_rst_busy", 32'(busyA), 32'h0);
        chk("mid_rst_valid", 32'(validA), 32'h0);
        chk("mid_rst_state", 32'(stA), 32'h01);
        tick();
        rstN = 1'b1;
        tick();
        chk("post_rst_valid0", 32'(validA), 32'h0);
        tick();
        chk("post_rst_valid1", 32'(validA), 32'h0);
        draw(8'h00, 20, e, d, f, bOk);
        chk("post_rst_data", 32'(d), 32'h02);

        // MAXTRIES=4: all four candidates rejected, fallback at E8
        sel = 2'd1;
        seed = 8'h08; seedLoad = 1'b1;
        tick();
        seedLoad = 1'b0;
        draw(8'h10, 30, e, d, f, bOk);
        chk("fb_data", 32'(d), 32'h00);
        chk("fb_flag", 32'(f), 32'h1);
        chk("fb_edge", 32'(e), 32'd8);
        chk("fb_held", 32'(fbB), 32'h1);
        chk("fb_state", 32'(stB), 32'h8E);
        draw(8'h00, 20, e, d, f, bOk);
        chk("fb_next_data", 32'(d), 32'h1C);
        chk("fb_cleared", 32'(f), 32'h0);

        // STEPS=8: valid at E9, value eight shifts from 0x01
        sel = 2'd2;
        expC = 8'h01;
        for (int i = 0; i < 8; i++) expC = lfsrStep(expC);
        draw(8'h00, 30, e, d, f, bOk);
        chk("steps8_edge", 32'(e), 32'd9);
        chk("steps8_data", 32'(d), 32'(expC));
        chk("steps8_hand", 32'(d), 32'h1C);

        // Free run: 255 draws visit every nonzero value once
        sel = 2'd0;
        distinct = 0;
        dupOrZero = 1'b0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int i = 0; i < 255; i++) begin
            draw(8'h00, 10, e, d, f, bOk);
            if (e == 0 || d == 8'h00 || seen[d]) dupOrZero = 1'b1;
            else begin
                seen[d] = 1'b1;
                distinct++;
            end
        end
        chk("freerun_distinct", 32'(distinct), 32'd255);
        chk("freerun_clean", 32'(dupOrZero), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
